// File: rtl/depuncturer_pkg.sv
// Shared rate codes, per-rate last-phase indices and pattern types for the depuncturer.
// Optional erase-flag ports are enabled by defining DEPUNCTURER_ERASE_FLAG_EN.
package depuncturer_pkg;

  localparam logic [1:0] RATE_1_2     = 2'b00;
  localparam logic [1:0] RATE_2_3     = 2'b01;
  localparam logic [1:0] RATE_3_4     = 2'b10;
  localparam logic [1:0] RATE_ILLEGAL = 2'b11;

  // Index of the final received bit within one puncturing period.
  localparam logic [1:0] LAST_PHASE_1_2 = 2'd1;
  localparam logic [1:0] LAST_PHASE_2_3 = 2'd2;
  localparam logic [1:0] LAST_PHASE_3_4 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic emit;
    logic slot_is_a;
    logic erase_other;
    logic last_phase;
  } pattern_t;

  function automatic logic [1:0] last_phase_of(input logic [1:0] rate);
    case (rate)
      RATE_2_3: last_phase_of = LAST_PHASE_2_3;
      RATE_3_4: last_phase_of = LAST_PHASE_3_4;
      default:  last_phase_of = LAST_PHASE_1_2;
    endcase
  endfunction

  // The illegal code runs the frame as rate 1/2.
  function automatic logic [1:0] sanitize_rate(input logic [1:0] rate);
    sanitize_rate = (rate == RATE_ILLEGAL) ? RATE_1_2 : rate;
  endfunction

endpackage

// File: rtl/depuncturer_puncture_pattern.sv
// Combinational puncturing table: {rate, phase} -> what the current received bit does.
// The per-phase actions coincide for all rates; rate only decides where the period ends.
module puncture_pattern
  import depuncturer_pkg::*;
(
  input  logic [1:0] rate_i,
  input  logic [1:0] phase_i,
  output pattern_t   pat_o
);

  always_comb begin
    pat_o            = '0;
    pat_o.last_phase = (phase_i == last_phase_of(rate_i));
    case (phase_i)
      2'd0: begin
        pat_o.slot_is_a = 1'b1;
      end
      2'd1: begin
        pat_o.emit = 1'b1;
      end
      2'd2: begin
        pat_o.emit        = 1'b1;
        pat_o.slot_is_a   = 1'b1;
        pat_o.erase_other = 1'b1;
      end
      default: begin
        pat_o.emit        = 1'b1;
        pat_o.erase_other = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/depuncturer.sv
// Depuncturer: rebuilds rate-1/2 {A,B} pairs from a punctured 802.11a bit stream.
// Define DEPUNCTURER_ERASE_FLAG_EN to expose OutEraseA/OutEraseB; otherwise erasures are zero fill.
module depuncturer
  import depuncturer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InBit,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 InStart,
  input  logic                 InLast,
  input  logic [1:0]           Rate,
  output logic                 OutA,
  output logic                 OutB,
`ifdef DEPUNCTURER_ERASE_FLAG_EN
  output logic                 OutEraseA,
  output logic                 OutEraseB,
`endif
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 OutLast,
  output logic [CNT_WIDTH-1:0] PairCount,
  output logic                 FrameError,
  output state_e               DbgState
);

  state_e                 state_q, state_d;
  logic [1:0]             rate_q, rate_d, phase_q, phase_d;
  logic                   held_q, held_d;
  logic                   out_a_q, out_a_d, out_b_q, out_b_d;
  logic                   valid_q, valid_d, last_q, last_d, ferr_q, ferr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
  logic                   era_q, era_d, erb_q, erb_d;
`endif

  logic       beat, start_beat, active, emit_now, out_hs;
  logic [1:0] rate_eff, phase_eff;
  pattern_t   pat;

  // Handshake: a beat or pair transfers on a rising edge where valid && ready; the single
  // output register frees up in the same cycle its pair is taken, so InReady = !OutValid || OutReady.
  assign beat       = InValid && InReady;
  assign start_beat = beat && InStart;
  assign active     = start_beat || (beat && (state_q == ST_RUN));
  assign out_hs     = valid_q && OutReady;
  assign rate_eff   = start_beat ? sanitize_rate(Rate) : rate_q;
  assign phase_eff  = start_beat ? 2'd0 : phase_q;
  assign emit_now   = active && (pat.emit || InLast);

  puncture_pattern u_pattern (
    .rate_i  (rate_eff),
    .phase_i (phase_eff),
    .pat_o   (pat)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_beat && !InLast) state_d = ST_RUN;
    else if (active && InLast) state_d = ST_IDLE;
  end

  always_comb begin
    InReady  = !valid_q || OutReady;
    DbgState = state_q;
  end

  always_comb begin
    rate_d  = start_beat ? rate_eff : rate_q;
    phase_d = phase_q;
    held_d  = held_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    last_d  = last_q;
    valid_d = out_hs ? 1'b0 : valid_q;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
    era_d   = era_q;
    erb_d   = erb_q;
`endif
    ferr_d  = (start_beat && ((Rate == RATE_ILLEGAL) || (state_q == ST_RUN)))
            || (active && InLast && !pat.last_phase);
    if (active) begin
      phase_d = (pat.last_phase || InLast) ? 2'd0 : phase_eff + 2'd1;
      if (!pat.emit) held_d = InBit;
    end
    if (emit_now) begin
      valid_d = 1'b1;
      last_d  = InLast;
      if (pat.emit && !pat.erase_other) begin
        out_a_d = held_q;
        out_b_d = InBit;
      end else if (pat.emit && !pat.slot_is_a) begin
        out_a_d = 1'b0;
        out_b_d = InBit;
      end else begin
        // Covers both the (A1,E) slot and a truncated frame whose bit is still unpaired.
        out_a_d = InBit;
        out_b_d = 1'b0;
      end
`ifdef DEPUNCTURER_ERASE_FLAG_EN
      era_d = pat.emit && pat.erase_other && !pat.slot_is_a;
      erb_d = !pat.emit || (pat.erase_other && pat.slot_is_a);
`endif
    end
    if (start_beat)                        cnt_d = '0;
    else if (out_hs && (cnt_q != '1))      cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rate_q  <= RATE_1_2;
      phase_q <= 2'd0;
      held_q  <= 1'b0;
      out_a_q <= 1'b0;
      out_b_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
      era_q   <= 1'b0;
      erb_q   <= 1'b0;
`endif
    end else begin
      rate_q  <= rate_d;
      phase_q <= phase_d;
      held_q  <= held_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
      era_q   <= era_d;
      erb_q   <= erb_d;
`endif
    end
  end

  assign OutA       = out_a_q;
  assign OutB       = out_b_q;
  assign OutValid   = valid_q;
  assign OutLast    = last_q;
  assign PairCount  = cnt_q;
  assign FrameError = ferr_q;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
  assign OutEraseA  = era_q;
  assign OutEraseB  = erb_q;
`endif

endmodule

// File: tb/tb_depuncturer.sv
// Scoreboard bench for depuncturer: directed frames push expected pairs {A,B,EA,EB,Last}; a monitor pops on handshake.
// Builds with or without DEPUNCTURER_ERASE_FLAG_EN.
module tb_depuncturer;
  import depuncturer_pkg::*;

  localparam int CW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InBit = 1'b0, InValid = 1'b0, InStart = 1'b0, InLast = 1'b0;
  logic [1:0]    Rate = 2'b00;
  logic          InReady, OutA, OutB, OutValid, OutLast, FrameError;
  logic          OutReady = 1'b1;
  logic [CW-1:0] PairCount;
  state_e        DbgState;
`ifdef DEPUNCTURER_ERASE_FLAG_EN
  logic          OutEraseA, OutEraseB;
`endif

  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;

  depuncturer #(.CNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .InBit(InBit), .InValid(InValid), .InReady(InReady),
    .InStart(InStart), .InLast(InLast), .Rate(Rate), .OutA(OutA), .OutB(OutB),
`ifdef DEPUNCTURER_ERASE_FLAG_EN
    .OutEraseA(OutEraseA), .OutEraseB(OutEraseB),
`endif
    .OutValid(OutValid), .OutReady(OutReady), .OutLast(OutLast),
    .PairCount(PairCount), .FrameError(FrameError), .DbgState(DbgState)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {A, B, EraseA, EraseB, Last}
  task automatic push(input logic a, input logic b, input logic ea, input logic eb, input logic l);
    exp_q.push_back({a, b, ea, eb, l});
  endtask

  // Monitor: handshake happens at the next rising edge when valid && ready at the falling edge.
  always @(negedge Clock) begin
    if (!Reset && FrameError) ferr_cnt++;
    if (!Reset && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got A=%0b B=%0b Last=%0b expected none", OutA, OutB, OutLast);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
`ifdef DEPUNCTURER_ERASE_FLAG_EN
        chk("pair", {27'd0, OutA, OutB, OutEraseA, OutEraseB, OutLast}, {27'd0, e});
`else
        chk("pair", {29'd0, OutA, OutB, OutLast}, {29'd0, e[4], e[3], e[0]});
`endif
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send(input logic b, input logic st, input logic lst, input logic [1:0] r);
    int n;
    InBit = b; InStart = st; InLast = lst; Rate = r; InValid = 1'b1;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: InReady stuck at %0b expected 1", InReady);
    end
    @(negedge Clock);
    InValid = 1'b0; InStart = 1'b0; InLast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || OutValid) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_in_time", {31'd0, n < 200}, 32'd1);
  endtask

  int f0;

  initial begin
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_outab", {30'd0, OutA, OutB}, 32'd0);
    chk("rst_outlast", {31'd0, OutLast}, 32'd0);
    chk("rst_paircount", {16'd0, PairCount}, 32'd0);
    chk("rst_frameerror", {31'd0, FrameError}, 32'd0);
    chk("rst_state", {31'd0, DbgState}, {31'd0, ST_IDLE});
    chk("rst_inready", {31'd0, InReady}, 32'd1);

    // R=1/2 plain frame
    f0 = ferr_cnt;
    push(1, 0, 0, 0, 0); push(1, 1, 0, 0, 1);
    send(1, 1, 0, RATE_1_2); send(0, 0, 0, RATE_1_2);
    send(1, 0, 0, RATE_1_2); send(1, 0, 1, RATE_1_2);
    drain();
    chk("t1_paircount", {16'd0, PairCount}, 32'd2);
    chk("t1_ferr", ferr_cnt - f0, 32'd0);
    chk("t1_state", {31'd0, DbgState}, {31'd0, ST_IDLE});

    // R=3/4 full period
    f0 = ferr_cnt;
    push(1, 1, 0, 0, 0); push(0, 0, 0, 1, 0); push(0, 1, 1, 0, 1);
    send(1, 1, 0, RATE_3_4); send(1, 0, 0, RATE_3_4);
    send(0, 0, 0, RATE_3_4); send(1, 0, 1, RATE_3_4);
    drain();
    chk("t2_paircount", {16'd0, PairCount}, 32'd3);
    chk("t2_ferr", ferr_cnt - f0, 32'd0);

    // R=2/3 with a 3-cycle output stall mid-frame
    f0 = ferr_cnt;
    push(1, 0, 0, 0, 0); push(1, 0, 0, 1, 0); push(0, 1, 0, 0, 0); push(1, 0, 0, 1, 1);
    fork
      begin
        send(1, 1, 0, RATE_2_3); send(0, 0, 0, RATE_2_3); send(1, 0, 0, RATE_2_3);
        send(0, 0, 0, RATE_2_3); send(1, 0, 0, RATE_2_3); send(1, 0, 1, RATE_2_3);
      end
      begin
        repeat (3) @(posedge Clock);
        #1 OutReady = 1'b0;
        @(negedge Clock);
        chk("t3_stall_outvalid", {31'd0, OutValid}, 32'd1);
        chk("t3_stall_inready", {31'd0, InReady}, 32'd0);
        repeat (2) @(posedge Clock);
        #1 OutReady = 1'b1;
      end
    join
    drain();
    chk("t3_paircount", {16'd0, PairCount}, 32'd4);
    chk("t3_ferr", ferr_cnt - f0, 32'd0);

    // R=3/4 truncated after the third bit
    f0 = ferr_cnt;
    push(1, 1, 0, 0, 0); push(0, 0, 0, 1, 1);
    send(1, 1, 0, RATE_3_4); send(1, 0, 0, RATE_3_4); send(0, 0, 1, RATE_3_4);
    drain();
    chk("t4_paircount", {16'd0, PairCount}, 32'd2);
    chk("t4_ferr", ferr_cnt - f0, 32'd1);
    chk("t4_state", {31'd0, DbgState}, {31'd0, ST_IDLE});

    // Illegal rate runs as 1/2
    f0 = ferr_cnt;
    push(1, 0, 0, 0, 0); push(1, 1, 0, 0, 1);
    send(1, 1, 0, RATE_ILLEGAL); send(0, 0, 0, RATE_ILLEGAL);
    send(1, 0, 0, RATE_ILLEGAL); send(1, 0, 1, RATE_ILLEGAL);
    drain();
    chk("t5a_ferr", ferr_cnt - f0, 32'd1);

    // Idle beats dropped; restart in RUN drops the held bit
    f0 = ferr_cnt;
    send(1, 0, 0, RATE_1_2); send(1, 0, 1, RATE_1_2);
    push(1, 0, 0, 0, 0); push(0, 1, 0, 0, 1);
    send(1, 1, 0, RATE_1_2); send(0, 0, 0, RATE_1_2); send(1, 0, 0, RATE_1_2);
    send(0, 1, 0, RATE_1_2); send(1, 0, 1, RATE_1_2);
    drain();
    chk("t5b_paircount", {16'd0, PairCount}, 32'd1);
    chk("t5b_ferr", ferr_cnt - f0, 32'd1);

    // Reset mid-pair with an unaccepted pair pending
    OutReady = 1'b0;
    push(1, 0, 0, 0, 0);
    send(1, 1, 0, RATE_1_2); send(0, 0, 0, RATE_1_2);
    InBit = 1'b1; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    Reset = 1'b1;
    exp_q.delete();
    @(negedge Clock);
    chk("t6_outvalid", {31'd0, OutValid}, 32'd0);
    chk("t6_paircount", {16'd0, PairCount}, 32'd0);
    chk("t6_state", {31'd0, DbgState}, {31'd0, ST_IDLE});
    Reset = 1'b0;
    OutReady = 1'b1;
    push(0, 1, 0, 0, 1);
    send(0, 1, 0, RATE_1_2); send(1, 0, 1, RATE_1_2);
    drain();
    chk("t6_post_paircount", {16'd0, PairCount}, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
